controlador_contexto: RTL and testbench
=======================================

Name: controlador_contexto

Overview:
- Sequencer that performs the context switch ordered by the process scheduler.
- It stalls the core, saves the outgoing process's register file and PC into an internal context table, then restores the incoming process's registers and PC.
- Sits between the scheduler (troca_contexto pulse plus process indices), the register file second port, and the PC register.

Parameters:
- NUM_PROC, 5: process slots in the context table.
- NUM_REGS, 32: registers saved and restored per process.
- DATA_W, 32: register and PC width.
- PROC_W, 3: process index width, ceil(log2(NUM_PROC)).
- REG_W, 5: register address width, ceil(log2(NUM_REGS)).

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low.
- troca_contexto, in, 1: one-cycle switch request from the scheduler.
- proc_saida, in, PROC_W: index of the outgoing process.
- proc_entrada, in, PROC_W: index of the incoming process.
- pc_atual, in, DATA_W: PC of the outgoing process.
- pc_inicio, in, DATA_W: start PC used for a process that has never been saved.
- rf_rdata, in, DATA_W: register file read data, combinational from rf_addr.
- stall, out, 1: freezes the core pipeline.
- rf_addr, out, REG_W: register file address.
- rf_wdata, out, DATA_W: register file write data.
- rf_we, out, 1: register file write enable.
- pc_load, out, 1: one-cycle load strobe for the PC.
- pc_novo, out, DATA_W: PC value loaded on pc_load.
- ocupado, out, 1: high in any state other than IDLE.
- concluido, out, 1: one-cycle completion pulse.
- pedido_perdido, out, 1: one-cycle pulse when a request is rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - All ctx_valid[NUM_PROC] bits cleared.
  - Table contents are don't-care.
  - Reset in the middle of a sequence aborts it immediately; a partially written register file is accepted.
- Input capture: in IDLE, a troca_contexto=1 sampled at rising edge T latches proc_saida, proc_entrada and pc_atual.
- Request rejection:
  - If either index >= NUM_PROC, no state change; pedido_perdido=1 in cycle T+1.
  - If troca_contexto=1 arrives while ocupado=1, the request is ignored; pedido_perdido pulses the next cycle and the current sequence continues unchanged.
- Same-index request (proc_saida==proc_entrada): no save or restore, stall stays 0, concluido=1 in cycle T+1.
- State SALVA (NUM_REGS cycles, starting T+1):
  - stall=1.
  - rf_addr = i, for i = 0..NUM_REGS-1.
  - ctx[saida][i] <= rf_rdata at the end of each cycle.
- State SALVA_PC (1 cycle): pc_tab[saida] <= pc latched at T; ctx_valid[saida] <= 1.
- State RESTAURA (NUM_REGS cycles):
  - rf_addr = i, rf_we=1.
  - rf_wdata = ctx[entrada][i] if ctx_valid[entrada], else 0.
- State RESTAURA_PC (1 cycle):
  - pc_load=1.
  - pc_novo = pc_tab[entrada] if valid, else pc_inicio (sampled this cycle).
- State FIM (1 cycle): concluido=1, stall=1; next state IDLE.
- Timing: stall is high for exactly 2*NUM_REGS+3 cycles (T+1 .. T+2*NUM_REGS+3).
- Datapath rules: rf_we is 0 outside RESTAURA; rf_addr and rf_wdata are 0 in IDLE.
- Register counter: REG_W bits, resets to 0 on each state entry; the terminal value NUM_REGS-1 drives the transition.
- Simultaneous events: a request arriving in the FIM cycle is rejected (ocupado=1), not queued.

Decomposition:
- Package contexto_pkg:
  - state enum: IDLE, SALVA, SALVA_PC, RESTAURA, RESTAURA_PC, FIM.
  - Default NUM_PROC, NUM_REGS and DATA_W constants.
- Sub-module tabela_contexto:
  - NUM_PROC*NUM_REGS x DATA_W storage plus NUM_PROC PC entries and valid bits.
  - One write port and one asynchronous read port.
  - The FSM stays in the top level.

Test Plan:
- First switch from 0 to 1: reset, load the register file with reg[i]=0x100+i, pc_atual=0x40, pc_inicio=0x200, pulse troca_contexto. Required response:
  - stall high for 67 cycles.
  - All 32 rf writes carry 0.
  - pc_load with pc_novo=0x200.
  - Single concluido pulse.
- Switch back from 1 to 0: the 32 restores write 0x100+i and pc_novo=0x40; ctx_valid[0] and ctx_valid[1] both read 1.
- Same index (2 to 2): concluido at T+1, stall never asserted, rf_we never asserted.
- Rejected requests:
  - Index 5 with NUM_PROC=5: pedido_perdido pulse, state stays IDLE.
  - A second troca_contexto during SALVA: pedido_perdido pulse, the original sequence completes with the original indices.
- Reset mid-RESTAURA at register 10: all outputs 0 immediately; ctx_valid is cleared, so the next switch into process 0 writes 0 to every register and loads pc_inicio.

Source files
------------

// File: rtl/controlador_contexto_pkg.sv
// Shared types and default sizes for the context-switch controller.
// Holds the sequencer state encoding and the default table geometry.
package contexto_pkg;

  localparam int DEF_NUM_PROC = 5;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_PROC_W   = $clog2(DEF_NUM_PROC);
  localparam int DEF_REG_W    = $clog2(DEF_NUM_REGS);

  typedef enum logic [2:0] {
    IDLE,
    SALVA,
    SALVA_PC,
    RESTAURA,
    RESTAURA_PC,
    FIM
  } estado_t;

endpackage

// File: rtl/controlador_contexto_if.sv
// Bundle between scheduler / register file / PC and the controller.
// master drives requests and rf read data; slave is the controller.
interface controlador_contexto_if
  import contexto_pkg::*;
#(
  parameter int PROC_W = DEF_PROC_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              troca_contexto;
  logic [PROC_W-1:0] proc_saida;
  logic [PROC_W-1:0] proc_entrada;
  logic [DATA_W-1:0] pc_atual;
  logic [DATA_W-1:0] pc_inicio;
  logic [DATA_W-1:0] rf_rdata;
  logic              stall;
  logic [REG_W-1:0]  rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  logic              pc_load;
  logic [DATA_W-1:0] pc_novo;
  logic              ocupado;
  logic              concluido;
  logic              pedido_perdido;

  modport master (
    output troca_contexto, proc_saida, proc_entrada,
    output pc_atual, pc_inicio, rf_rdata,
    input  stall, rf_addr, rf_wdata, rf_we,
    input  pc_load, pc_novo, ocupado, concluido,
    input  pedido_perdido
  );

  modport slave (
    input  troca_contexto, proc_saida, proc_entrada,
    input  pc_atual, pc_inicio, rf_rdata,
    output stall, rf_addr, rf_wdata, rf_we,
    output pc_load, pc_novo, ocupado, concluido,
    output pedido_perdido
  );

endinterface

// File: rtl/controlador_contexto_tabela.sv
// Context table: per-process register images, saved PC and valid bit.
// Ports: one write port (reg or pc), one async read port; valid bits reset.
module tabela_contexto #(
  parameter int NUM_PROC = 5,
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int PROC_W   = 3,
  parameter int REG_W    = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_reg,
  input  logic              wr_pc,
  input  logic [PROC_W-1:0] wr_proc,
  input  logic [REG_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PROC_W-1:0] rd_proc,
  input  logic [REG_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rd_pc,
  output logic              rd_valid
);

  logic [DATA_W-1:0] ctx    [NUM_PROC][NUM_REGS];
  logic [DATA_W-1:0] pc_tab [NUM_PROC];
  logic [NUM_PROC-1:0] ctx_valid;

  // Storage contents are don't-care after reset; only valid bits clear.
  always_ff @(posedge clock) begin
    if (wr_reg) ctx[wr_proc][wr_idx] <= wr_data;
    if (wr_pc)  pc_tab[wr_proc] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctx_valid <= '0;
    end else if (wr_pc) begin
      ctx_valid[wr_proc] <= 1'b1;
    end
  end

  assign rd_data  = ctx[rd_proc][rd_idx];
  assign rd_pc    = pc_tab[rd_proc];
  assign rd_valid = ctx_valid[rd_proc];

endmodule

// File: rtl/controlador_contexto.sv
// Context-switch sequencer: stall, save regs+PC, restore regs+PC.
// Ports: clock, reset (async low), bus (slave side of the bundle).
module controlador_contexto
  import contexto_pkg::*;
#(
  parameter int NUM_PROC = DEF_NUM_PROC,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W
) (
  input logic clock,
  input logic reset,
  controlador_contexto_if.slave bus
);

  localparam int PROC_W = $clog2(NUM_PROC);
  localparam int REG_W  = $clog2(NUM_REGS);
  localparam logic [PROC_W-1:0] P_MAX  = PROC_W'(NUM_PROC - 1);
  localparam logic [REG_W-1:0]  ULTIMO = REG_W'(NUM_REGS - 1);

  estado_t           estado;
  logic [PROC_W-1:0] saida_q;
  logic [PROC_W-1:0] entrada_q;
  logic [DATA_W-1:0] pc_q;
  logic [REG_W-1:0]  idx;
  logic              stall_q;
  logic              we_q;
  logic              load_q;
  logic              ocup_q;
  logic              concl_q;
  logic              perd_q;

  logic              fora;
  logic              mesmo;
  logic              ultimo;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rd_pc;
  logic              rd_valid;
  logic [DATA_W-1:0] wr_data;

  assign fora   = (bus.proc_saida > P_MAX) ||
                  (bus.proc_entrada > P_MAX);
  assign mesmo  = bus.proc_saida == bus.proc_entrada;
  assign ultimo = idx == ULTIMO;

  // The single table write port carries the PC during SALVA_PC.
  assign wr_data = (estado == SALVA_PC) ? pc_q : bus.rf_rdata;

  tabela_contexto #(
    .NUM_PROC (NUM_PROC),
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .PROC_W   (PROC_W),
    .REG_W    (REG_W)
  ) u_tabela (
    .clock    (clock),
    .reset    (reset),
    .wr_reg   (estado == SALVA),
    .wr_pc    (estado == SALVA_PC),
    .wr_proc  (saida_q),
    .wr_idx   (idx),
    .wr_data  (wr_data),
    .rd_proc  (entrada_q),
    .rd_idx   (idx),
    .rd_data  (rd_data),
    .rd_pc    (rd_pc),
    .rd_valid (rd_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= IDLE;
      saida_q   <= '0;
      entrada_q <= '0;
      pc_q      <= '0;
      idx       <= '0;
      stall_q   <= 1'b0;
      we_q      <= 1'b0;
      load_q    <= 1'b0;
      ocup_q    <= 1'b0;
      concl_q   <= 1'b0;
      perd_q    <= 1'b0;
    end else begin
      concl_q <= 1'b0;
      perd_q  <= 1'b0;
      load_q  <= 1'b0;
      unique case (estado)
        IDLE: begin
          if (bus.troca_contexto) begin
            if (fora) begin
              perd_q <= 1'b1;
            end else if (mesmo) begin
              concl_q <= 1'b1;
            end else begin
              saida_q   <= bus.proc_saida;
              entrada_q <= bus.proc_entrada;
              pc_q      <= bus.pc_atual;
              idx       <= '0;
              stall_q   <= 1'b1;
              ocup_q    <= 1'b1;
              estado    <= SALVA;
            end
          end
        end
        SALVA: begin
          if (ultimo) begin
            idx    <= '0;
            estado <= SALVA_PC;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SALVA_PC: begin
          idx    <= '0;
          we_q   <= 1'b1;
          estado <= RESTAURA;
        end
        RESTAURA: begin
          if (ultimo) begin
            idx    <= '0;
            we_q   <= 1'b0;
            load_q <= 1'b1;
            estado <= RESTAURA_PC;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RESTAURA_PC: begin
          concl_q <= 1'b1;
          estado  <= FIM;
        end
        FIM: begin
          stall_q <= 1'b0;
          ocup_q  <= 1'b0;
          estado  <= IDLE;
        end
        default: estado <= IDLE;
      endcase
      // Requests during a sequence are dropped, never queued.
      if (estado != IDLE && bus.troca_contexto) perd_q <= 1'b1;
    end
  end

  assign bus.stall          = stall_q;
  assign bus.rf_addr        = idx;
  assign bus.rf_we          = we_q;
  assign bus.rf_wdata       = (we_q && rd_valid) ? rd_data : '0;
  assign bus.pc_load        = load_q;
  // Never-saved process starts at pc_inicio as seen in this cycle.
  assign bus.pc_novo        = !load_q  ? '0 :
                              rd_valid ? rd_pc : bus.pc_inicio;
  assign bus.ocupado        = ocup_q;
  assign bus.concluido      = concl_q;
  assign bus.pedido_perdido = perd_q;

endmodule

// File: tb/tb_controlador_contexto.sv
// Bench for controlador_contexto: vector table plus reset/abort sequences.
// Models a 32x32 register file answering rf_addr combinationally.
module tb_controlador_contexto;

  logic clock;
  logic reset;
  logic rf_init;
  logic [31:0] rf [32];

  int applied;
  int miscompares;

  controlador_contexto_if bus ();

  controlador_contexto dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + 32'(i);
    end else if (bus.rf_we) begin
      rf[bus.rf_addr] <= bus.rf_wdata;
    end
  end

  assign bus.rf_rdata = rf[bus.rf_addr];

  typedef struct {
    logic [2:0]  saida;
    logic [2:0]  entrada;
    logic [31:0] pc_atual;
    logic [31:0] pc_ini;
    int          stall;
    int          we;
    bit          zero;
    logic [31:0] pc;
    int          concl_at;
    int          perd;
    int          inj;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"},
        64'({bus.stall, bus.rf_we, bus.pc_load, bus.ocupado,
             bus.concluido, bus.pedido_perdido, bus.rf_addr}),
        64'd0);
    chk({nm, "_data"}, {bus.rf_wdata, bus.pc_novo}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int nst, lst, nocc, nwe, derr, npl, nc, cat, np;
    logic [31:0] pcs, ew;
    nst = 0; lst = 0; nocc = 0; nwe = 0; derr = 0;
    npl = 0; nc = 0; cat = 0; np = 0; pcs = '0;
    @(negedge clock);
    bus.proc_saida     = v.saida;
    bus.proc_entrada   = v.entrada;
    bus.pc_atual       = v.pc_atual;
    bus.pc_inicio      = v.pc_ini;
    bus.troca_contexto = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clock);
      if (bus.stall) begin nst++; lst = k; end
      if (bus.ocupado) nocc++;
      ew = v.zero ? 32'h0 : 32'h100 + 32'(nwe);
      if (bus.rf_we) begin
        if (bus.rf_addr !== 5'(nwe) || bus.rf_wdata !== ew) derr++;
        nwe++;
      end else if (!bus.stall &&
                   (bus.rf_addr !== '0 || bus.rf_wdata !== '0)) begin
        derr++;
      end
      if (bus.pc_load) begin npl++; pcs = bus.pc_novo; end
      if (bus.concluido) begin nc++; cat = k; end
      if (bus.pedido_perdido) np++;
      if (k == v.inj) begin
        bus.proc_saida     = 3'd0;
        bus.proc_entrada   = 3'd4;
        bus.pc_atual       = 32'hdead;
        bus.troca_contexto = 1'b1;
      end else begin
        bus.troca_contexto = 1'b0;
      end
    end
    chk({nm, "_stall_n"},   64'(nst),  64'(v.stall));
    chk({nm, "_stall_end"}, 64'(lst),  64'(v.stall));
    chk({nm, "_ocupado_n"}, 64'(nocc), 64'(v.stall));
    chk({nm, "_we_n"},      64'(nwe),  64'(v.we));
    chk({nm, "_wdata_err"}, 64'(derr), 64'd0);
    chk({nm, "_pcload_n"},  64'(npl),  64'(v.we > 0 ? 1 : 0));
    chk({nm, "_pc_novo"},   64'(pcs),  64'(v.pc));
    chk({nm, "_concl_n"},   64'(nc),   64'(v.concl_at > 0 ? 1 : 0));
    chk({nm, "_concl_at"},  64'(cat),  64'(v.concl_at));
    chk({nm, "_perdido_n"}, 64'(np),   64'(v.perd));
  endtask

  initial begin
    vec_t vr;
    applied = 0;
    miscompares = 0;

    vt[0] = '{3'd0, 3'd1, 32'h040, 32'h200, 67, 32, 1'b1, 32'h200, 67, 0, 0};
    vt[1] = '{3'd1, 3'd0, 32'h044, 32'h204, 67, 32, 1'b0, 32'h040, 67, 0, 0};
    vt[2] = '{3'd2, 3'd2, 32'h048, 32'h208, 0, 0, 1'b1, 32'h0, 1, 0, 0};
    vt[3] = '{3'd5, 3'd0, 32'h04c, 32'h20c, 0, 0, 1'b1, 32'h0, 0, 1, 0};
    vt[4] = '{3'd0, 3'd6, 32'h050, 32'h210, 0, 0, 1'b1, 32'h0, 0, 1, 0};
    vt[5] = '{3'd3, 3'd4, 32'h300, 32'h400, 67, 32, 1'b1, 32'h400, 67, 0, 0};
    vt[6] = '{3'd4, 3'd3, 32'h500, 32'h600, 67, 32, 1'b0, 32'h300, 67, 0, 0};
    vt[7] = '{3'd3, 3'd2, 32'h700, 32'h800, 67, 32, 1'b1, 32'h800, 67, 1, 5};
    vt[8] = '{3'd2, 3'd3, 32'h900, 32'ha00, 67, 32, 1'b0, 32'h700, 67, 1, 67};

    reset = 1'b0;
    rf_init = 1'b1;
    bus.troca_contexto = 1'b0;
    bus.proc_saida     = '0;
    bus.proc_entrada   = '0;
    bus.pc_atual       = '0;
    bus.pc_inicio      = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_zero("reset");
    chk("reset_valid", 64'(dut.u_tabela.ctx_valid), 64'd0);
    reset = 1'b1;
    rf_init = 1'b0;

    for (int i = 0; i < 2; i++) run_vec(vt[i], $sformatf("v%0d", i));
    chk("valid_0_1", 64'(dut.u_tabela.ctx_valid[1:0]), 64'd3);
    for (int i = 2; i < 9; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Abort a 1->0 switch in RESTAURA at register 10.
    @(negedge clock);
    bus.proc_saida     = 3'd1;
    bus.proc_entrada   = 3'd0;
    bus.pc_atual       = 32'hc0;
    bus.troca_contexto = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clock);
      bus.troca_contexto = 1'b0;
    end
    chk("mid_restaura", 64'({bus.rf_we, bus.rf_addr}), 64'({1'b1, 5'd10}));
    reset = 1'b0;
    #1;
    chk_zero("abort");
    chk("abort_valid", 64'(dut.u_tabela.ctx_valid), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    vr = '{3'd1, 3'd0, 32'hd0, 32'hb00, 67, 32, 1'b1, 32'hb00, 67, 0, 0};
    run_vec(vr, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
